// File: rtl/bus_arb4_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : bus_arb4_if
// Purpose  : Handshake bundle between four bus masters and the bus_arb4
//            round-robin arbiter.
// Signals  : req[3:0]  - level request per master, held until granted and done
//            done      - owner signals end of transfer
//            grant[3:0]- one-hot grant, zero when the bus is idle
//            sel[1:0]  - binary owner index for the shared datapath mux
//            busy      - a grant is active
//            tmo       - one-cycle pulse after a grant is revoked by timeout
// Modports : master (drives req/done), slave (the arbiter)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
interface bus_arb4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  busy,
        input  tmo
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output busy,
        output tmo
    );
endinterface
`default_nettype wire

// File: rtl/bus_arb4.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : bus_arb4
// Purpose  : Four-master round-robin bus arbiter with hold timeout.
//            A grant is issued one cycle after a request is seen in IDLE and
//            is held until done, the owner drops its request, or the hold
//            counter hits TMO_MAX. Every release is followed by one idle
//            turnaround cycle before the next grant.
// Params   : TMO_MAX - maximum cycles a master may hold the grant (1..255)
// Ports    : clk     - rising-edge clock
//            reset   - synchronous, active-high reset
//            bus     - bus_arb4_if.slave (req, done, grant, sel, busy, tmo)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module bus_arb4 #(
    parameter int TMO_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    bus_arb4_if.slave   bus
);

    generate
        if ((TMO_MAX < 1) || (TMO_MAX > 255)) begin : g_tmo_range_check
            $error("bus_arb4: TMO_MAX must be in 1..255");
        end
    endgenerate

    // Counter value seen in the last permitted BUSY cycle.
    localparam logic [7:0] HOLD_LAST = 8'(TMO_MAX - 1);
    localparam logic [7:0] HOLD_SAT  = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;
    logic [3:0] grant_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic       tmo_q;

    logic [1:0] winner;
    logic       win_valid;
    logic       owner_req;
    logic       at_limit;
    logic       release_now;

    // Round-robin search starting at ptr. Scanning offsets from highest to
    // lowest lets the closest set request (smallest offset) win last.
    always_comb begin
        winner    = ptr;
        win_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr + 2'(k)]) begin
                winner    = ptr + 2'(k);
                win_valid = 1'b1;
            end
        end
    end

    assign owner_req   = bus.req[sel_q];
    assign at_limit    = (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || !owner_req || at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= 4'b0000;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state    <= BUSY;
                        grant_q  <= 4'b0001 << winner;
                        sel_q    <= winner;
                        busy_q   <= 1'b1;
                        ptr      <= winner + 2'd1;
                        hold_cnt <= 8'd0;
                    end else begin
                        // sel keeps the last owner so the datapath mux is stable.
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state   <= IDLE;
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                        // A coincident done or request drop is a normal
                        // release, so tmo only flags a pure timeout.
                        tmo_q   <= at_limit && !bus.done && owner_req;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.tmo   = tmo_q;

endmodule
`default_nettype wire

// File: doc/bus_arb4.md
BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 Parameter TMO_MAX, default 15: maximum cycles a master may hold the grant; legal range 1..255.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port req, input, 4: request from masters 0..3; level, held until granted and done.
REQ-005 Port done, input, 1: current owner signals end of transfer; sampled only in BUSY.
REQ-006 Port grant, output, 4: one-hot grant, registered.
REQ-007 Port sel, output, 2: binary owner index; drives sel of the shared 32-bit 4:1 datapath mux.
REQ-008 Port busy, output, 1: high while a grant is active.
REQ-009 Port tmo, output, 1: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 FSM states are IDLE and BUSY; no other states are reachable.
REQ-011 IDLE with req == 0: stays IDLE; grant = 0, busy = 0.
REQ-012 IDLE with req != 0: on the next edge, selects the winner by round-robin, sets grant to one-hot(winner), sets sel = winner and busy = 1, and moves to BUSY.
REQ-013 Grant latency is exactly 1 cycle from the first cycle req is sampled high in IDLE.
REQ-014 Round-robin: search starts at index ptr and proceeds ptr, ptr+1, ... modulo 4; the first set req bit wins.
REQ-015 On grant to index i, ptr becomes (i+1) mod 4.
REQ-016 BUSY: grant, sel, and the owner are frozen; req changes from non-owners have no effect.
REQ-017 BUSY release conditions (any one): done = 1; req[owner] = 0; hold counter reaches TMO_MAX.
REQ-018 On release: the next edge sets grant = 0 and busy = 0 and moves to IDLE, giving one mandatory turnaround cycle before any new grant.
REQ-019 Hold counter is 8 bits; it is cleared on entry to BUSY and increments once per BUSY cycle; it saturates and does not wrap.
REQ-020 Timeout release occurs when the counter equals TMO_MAX-1 in a cycle with no done and req[owner] still high; tmo is asserted for exactly the IDLE cycle that follows.
REQ-021 If done (or req[owner] dropping) coincides with the timeout cycle, it is a normal release and tmo stays 0.
REQ-022 In IDLE, sel holds the last owner index, so mux output is stable.
REQ-023 grant is always one-hot or zero, and grant[sel] = busy.

Reset
REQ-024 When reset = 1 at a rising edge: state = IDLE, grant = 0, sel = 0, busy = 0, tmo = 0, ptr = 0, counter = 0.
REQ-025 Reset overrides all other inputs, including during BUSY; any grant is dropped on that same edge, with no tmo.
REQ-026 In the first cycle after reset deasserts, req is arbitrated normally with ptr = 0.

Verification
REQ-027 Single request: reset, then req = 0001 held and done pulsed 3 cycles after the grant -> grant = 0001 and sel = 0 one cycle after req; busy for 4 cycles; IDLE 1 cycle; re-grant to master 0.
REQ-028 Rotation: req = 1111 held continuously, done pulsed each BUSY cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
REQ-029 Pointer skip: after a grant to 1 (ptr = 2), req = 0011 -> next grant is 0001 (index 0) and ptr becomes 1.
REQ-030 Timeout: TMO_MAX = 4, req = 0100 held, no done -> grant high for exactly 4 cycles, then tmo = 1 for 1 cycle and grant = 0.
REQ-031 Timeout tie: TMO_MAX = 4, done asserted in the 4th BUSY cycle -> release with tmo = 0.
REQ-032 Mid-grant reset: reset asserted in the 2nd BUSY cycle -> next cycle grant = 0, sel = 0, busy = 0, tmo = 0; after reset, req = 1000 yields grant 1000 with ptr rebuilt from 0.
